// File: rtl/conv_pkg.sv
// Shared parameters and FSM state type for the convolution tile fetcher.
package conv_pkg;

  localparam int TILE_SIZE    = 4;
  localparam int KERNEL_SIZE  = 3;
  localparam int CHANNELS     = 3;
  localparam int DATA_WIDTH   = 8;
  localparam int KERNEL_WIDTH = 8;
  localparam int IN_ADDR_W    = 15;
  localparam int K_ADDR_W     = 8;

  localparam int IN_LEN    = TILE_SIZE * TILE_SIZE * CHANNELS;
  localparam int K_LEN     = KERNEL_SIZE * KERNEL_SIZE * CHANNELS;
  localparam int IN_FLAT_W = IN_LEN * DATA_WIDTH;
  localparam int K_FLAT_W  = K_LEN * KERNEL_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/conv_tile_fetch_if.sv
// Command, BRAM and tile-handshake signals of the tile fetcher; slave = fetcher side.
interface conv_tile_fetch_if;
  import conv_pkg::*;

  logic                    start;
  logic                    load_kernel;
  logic [IN_ADDR_W-1:0]    in_base;
  logic [K_ADDR_W-1:0]     k_base;
  logic                    in_en;
  logic [IN_ADDR_W-1:0]    in_addr;
  logic [DATA_WIDTH-1:0]   in_dout;
  logic                    k_en;
  logic [K_ADDR_W-1:0]     k_addr;
  logic [KERNEL_WIDTH-1:0] k_dout;
  logic [IN_FLAT_W-1:0]    flat_input;
  logic [K_FLAT_W-1:0]     flat_kernel;
  logic                    tile_valid;
  logic                    tile_ready;
  logic                    busy;
  logic                    done;

  modport slave (
    input  start, load_kernel, in_base, k_base, in_dout, k_dout, tile_ready,
    output in_en, in_addr, k_en, k_addr, flat_input, flat_kernel, tile_valid, busy, done
  );

  modport master (
    output start, load_kernel, in_base, k_base, in_dout, k_dout, tile_ready,
    input  in_en, in_addr, k_en, k_addr, flat_input, flat_kernel, tile_valid, busy, done
  );

endinterface

// File: rtl/conv_tile_fetch_bram_read_seq.sv
// One BRAM read stream: issues LEN consecutive addresses after launch and tags
// the returning data with its destination slot in the packed vector.
module bram_read_seq #(
  parameter int LEN    = 48,
  parameter int W      = 8,
  parameter int ADDR_W = 15,
  parameter int LAT    = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      launch,
  input  logic [ADDR_W-1:0]         base,
  output logic                      en,
  output logic [ADDR_W-1:0]         addr,
  output logic                      cap_en,
  output logic [$clog2(LEN*W)-1:0]  cap_lsb,
  output logic                      issue_last,
  output logic                      cap_last
);

  localparam int CNT_W = $clog2(LEN + 1);
  localparam int LSB_W = $clog2(LEN * W);

  logic              active_q,  active_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [ADDR_W-1:0] base_q,    base_d;
  logic              en_q,      en_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic [LAT-1:0]    pipe_q,    pipe_d;
  logic [CNT_W-1:0]  cap_idx_q, cap_idx_d;

  assign en         = en_q;
  assign addr       = addr_q;
  assign cap_en     = pipe_q[LAT-1];
  assign cap_lsb    = LSB_W'((LEN - 1 - int'(cap_idx_q)) * W);
  assign issue_last = active_q && (cnt_q == CNT_W'(LEN - 1));
  assign cap_last   = cap_en && (cap_idx_q == CNT_W'(LEN - 1));

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves it unassigned, which would infer a latch.
    active_d  = active_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    en_d      = 1'b0;
    addr_d    = addr_q;
    cap_idx_d = cap_idx_q;
    // Issue flags walk down the pipe in step with the BRAM read latency.
    pipe_d    = LAT'({pipe_q, en_q});

    if (launch) begin
      active_d  = 1'b1;
      cnt_d     = '0;
      base_d    = base;
      cap_idx_d = '0;
    end else if (active_q) begin
      en_d   = 1'b1;
      addr_d = base_q + ADDR_W'(cnt_q);
      cnt_d  = cnt_q + 1'b1;
      if (issue_last) active_d = 1'b0;
    end

    if (cap_en) cap_idx_d = cap_idx_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (reset) begin
      active_q  <= 1'b0;
      cnt_q     <= '0;
      base_q    <= '0;
      en_q      <= 1'b0;
      addr_q    <= '0;
      pipe_q    <= '0;
      cap_idx_q <= '0;
    end else begin
      active_q  <= active_d;
      cnt_q     <= cnt_d;
      base_q    <= base_d;
      en_q      <= en_d;
      addr_q    <= addr_d;
      pipe_q    <= pipe_d;
      cap_idx_q <= cap_idx_d;
    end
  end

endmodule

// File: rtl/conv_tile_fetch.sv
// Fetches one input tile and optionally one kernel from BRAM, packs them into
// flat vectors and holds them under valid/ready until the PE takes them.
module conv_tile_fetch
  import conv_pkg::*;
#(
  parameter int BRAM_LAT = 1
) (
  input logic              clk,
  input logic              reset,
  conv_tile_fetch_if.slave bus
);

  localparam int IN_LSB_W = $clog2(IN_FLAT_W);
  localparam int K_LSB_W  = $clog2(K_FLAT_W);

  fetch_state_e         state_q, state_d;
  logic                 done_q, done_d;
  logic [IN_FLAT_W-1:0] flat_input_q, flat_input_d;
  logic [K_FLAT_W-1:0]  flat_kernel_q, flat_kernel_d;

  logic                 launch_in, launch_k;
  logic                 in_en, k_en;
  logic [IN_ADDR_W-1:0] in_addr;
  logic [K_ADDR_W-1:0]  k_addr;
  logic                 in_cap_en, k_cap_en;
  logic [IN_LSB_W-1:0]  in_cap_lsb;
  logic [K_LSB_W-1:0]   k_cap_lsb;
  logic                 in_issue_last, in_cap_last;
  logic                 k_issue_last, k_cap_last;
  logic                 unused_k_status;

  // The kernel is never longer than the tile, so the input stream alone paces the FSM.
  assign unused_k_status = k_issue_last | k_cap_last;

  assign launch_in = (state_q == IDLE) && bus.start;
  assign launch_k  = launch_in && bus.load_kernel;

  bram_read_seq #(
    .LEN(IN_LEN), .W(DATA_WIDTH), .ADDR_W(IN_ADDR_W), .LAT(BRAM_LAT)
  ) u_in_seq (
    .clk       (clk),
    .reset     (reset),
    .launch    (launch_in),
    .base      (bus.in_base),
    .en        (in_en),
    .addr      (in_addr),
    .cap_en    (in_cap_en),
    .cap_lsb   (in_cap_lsb),
    .issue_last(in_issue_last),
    .cap_last  (in_cap_last)
  );

  bram_read_seq #(
    .LEN(K_LEN), .W(KERNEL_WIDTH), .ADDR_W(K_ADDR_W), .LAT(BRAM_LAT)
  ) u_k_seq (
    .clk       (clk),
    .reset     (reset),
    .launch    (launch_k),
    .base      (bus.k_base),
    .en        (k_en),
    .addr      (k_addr),
    .cap_en    (k_cap_en),
    .cap_lsb   (k_cap_lsb),
    .issue_last(k_issue_last),
    .cap_last  (k_cap_last)
  );

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE:  if (bus.start)      state_d = FETCH;
      FETCH: if (in_issue_last)  state_d = DRAIN;
      DRAIN: if (in_cap_last)    state_d = HOLD;
      HOLD: begin
        if (bus.tile_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Packing: element i lands at slot LEN-1-i, so element 0 occupies the MSBs.
  always_comb begin
    flat_input_d  = flat_input_q;
    flat_kernel_d = flat_kernel_q;
    if (in_cap_en) flat_input_d[in_cap_lsb +: DATA_WIDTH]  = bus.in_dout;
    if (k_cap_en)  flat_kernel_d[k_cap_lsb +: KERNEL_WIDTH] = bus.k_dout;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      done_q        <= 1'b0;
      // NOTE: the packed vectors are ordinary registers, not RAM, so they take reset and read as zero until the first capture.
      flat_input_q  <= '0;
      flat_kernel_q <= '0;
    end else begin
      state_q       <= state_d;
      done_q        <= done_d;
      flat_input_q  <= flat_input_d;
      flat_kernel_q <= flat_kernel_d;
    end
  end

  assign bus.in_en       = in_en;
  assign bus.in_addr     = in_addr;
  assign bus.k_en        = k_en;
  assign bus.k_addr      = k_addr;
  assign bus.flat_input  = flat_input_q;
  assign bus.flat_kernel = flat_kernel_q;
  assign bus.tile_valid  = (state_q == HOLD);
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;

endmodule

// File: tb/tb_conv_tile_fetch.sv
// Bench for conv_tile_fetch: BRAM_LAT=1 and BRAM_LAT=2 instances, address-derived BRAM
// contents, and a packed-vector reference model built from the element ordering rules.
module tb_conv_tile_fetch;
  import conv_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic                 start = 1'b0, load_kernel = 1'b0, tile_ready = 1'b0, sel2 = 1'b0;
  logic [IN_ADDR_W-1:0] in_base = '0;
  logic [K_ADDR_W-1:0]  k_base  = '0;

  int n_chk = 0;
  int n_pass = 0;

  conv_tile_fetch_if if1 ();
  conv_tile_fetch_if if2 ();

  conv_tile_fetch #(.BRAM_LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
  conv_tile_fetch #(.BRAM_LAT(2)) dut2 (.clk(clk), .reset(reset), .bus(if2.slave));

  assign if1.start       = start & ~sel2;
  assign if2.start       = start & sel2;
  assign if1.tile_ready  = tile_ready & ~sel2;
  assign if2.tile_ready  = tile_ready & sel2;
  assign if1.load_kernel = load_kernel;
  assign if2.load_kernel = load_kernel;
  assign if1.in_base     = in_base;
  assign if2.in_base     = in_base;
  assign if1.k_base      = k_base;
  assign if2.k_base      = k_base;

  // BRAM models: contents are a function of the address, read latency 1 and 2.
  logic [7:0] a1_d, k1_d, a2_d1, a2_d2, k2_d1, k2_d2;
  always @(posedge clk) begin
    a1_d  <= if1.in_addr[7:0];
    k1_d  <= 8'h80 + if1.k_addr;
    a2_d1 <= if2.in_addr[7:0];
    a2_d2 <= a2_d1;
    k2_d1 <= 8'h80 + if2.k_addr;
    k2_d2 <= k2_d1;
  end
  assign if1.in_dout = a1_d;
  assign if1.k_dout  = k1_d;
  assign if2.in_dout = a2_d2;
  assign if2.k_dout  = k2_d2;

  logic                 cur_valid, cur_done, cur_busy;
  logic [IN_FLAT_W-1:0] cur_input;
  logic [K_FLAT_W-1:0]  cur_kernel;
  assign cur_valid  = sel2 ? if2.tile_valid  : if1.tile_valid;
  assign cur_done   = sel2 ? if2.done        : if1.done;
  assign cur_busy   = sel2 ? if2.busy        : if1.busy;
  assign cur_input  = sel2 ? if2.flat_input  : if1.flat_input;
  assign cur_kernel = sel2 ? if2.flat_kernel : if1.flat_kernel;

  // Issue monitor for the BRAM_LAT=1 instance, sampled just after each edge.
  logic [IN_ADDR_W-1:0] in_q[$];
  logic [K_ADDR_W-1:0]  k_q[$];
  int done_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (if1.in_en === 1'b1) in_q.push_back(if1.in_addr);
    if (if1.k_en === 1'b1)  k_q.push_back(if1.k_addr);
    if (cur_done === 1'b1)  done_cnt++;
  end

  logic [K_FLAT_W-1:0] model_kernel = '0;

  function automatic logic [IN_FLAT_W-1:0] exp_input(input logic [IN_ADDR_W-1:0] base);
    logic [IN_FLAT_W-1:0] v;
    logic [IN_ADDR_W-1:0] a;
    v = '0;
    for (int i = 0; i < IN_LEN; i++) begin
      a = base + IN_ADDR_W'(i);
      v = {v[IN_FLAT_W-DATA_WIDTH-1:0], a[7:0]};
    end
    return v;
  endfunction

  function automatic logic [K_FLAT_W-1:0] exp_kernel(input logic [K_ADDR_W-1:0] base);
    logic [K_FLAT_W-1:0] v;
    logic [K_ADDR_W-1:0] a;
    v = '0;
    for (int i = 0; i < K_LEN; i++) begin
      a = base + K_ADDR_W'(i);
      v = {v[K_FLAT_W-KERNEL_WIDTH-1:0], 8'h80 + a};
    end
    return v;
  endfunction

  // Number of issued input addresses that deviate from base, base+1, ...; -1 on a count mismatch.
  function automatic int in_addr_errs(input logic [IN_ADDR_W-1:0] base);
    int bad = 0;
    if (in_q.size() != IN_LEN) return -1;
    for (int i = 0; i < IN_LEN; i++)
      if (in_q[i] !== IN_ADDR_W'(base + IN_ADDR_W'(i))) bad++;
    return bad;
  endfunction

  function automatic int k_addr_errs(input logic [K_ADDR_W-1:0] base, input logic lk);
    int bad = 0;
    if (k_q.size() != (lk ? K_LEN : 0)) return -1;
    for (int i = 0; i < k_q.size(); i++)
      if (k_q[i] !== K_ADDR_W'(base + K_ADDR_W'(i))) bad++;
    return bad;
  endfunction

  task automatic launch(input logic [IN_ADDR_W-1:0] ib, input logic [K_ADDR_W-1:0] kb,
                        input logic lk, output int lat);
    @(negedge clk);
    in_q.delete();
    k_q.delete();
    in_base = ib; k_base = kb; load_kernel = lk; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (cur_valid !== 1'b1 && lat < 300) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic accept();
    tile_ready = 1'b1;
    @(negedge clk);
    tile_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({if1.flat_input, if1.flat_kernel} !== '0)
      $display("FAIL reset_flat: got %h / %h want 0", if1.flat_input, if1.flat_kernel);
    else n_pass++;
    reset = 1'b0;
    in_q.delete();
    k_q.delete();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_chk++;
      if ({if1.in_en, if1.k_en, if1.tile_valid, if1.busy, if1.done} !== 5'b0)
        $display("FAIL reset_idle cyc %0d: got en/en/valid/busy/done=%b want 00000", c,
                 {if1.in_en, if1.k_en, if1.tile_valid, if1.busy, if1.done});
      else n_pass++;
    end
    n_chk++;
    if (in_q.size() + k_q.size() != 0)
      $display("FAIL reset_en_pulses: got %0d want 0", in_q.size() + k_q.size());
    else n_pass++;
  endtask

  task automatic test_basic();
    int lat;
    done_cnt = 0;
    launch(15'h0000, 8'h00, 1'b1, lat);
    model_kernel = exp_kernel(8'h00);
    n_chk++;
    if (lat != 50) $display("FAIL basic_latency: got %0d want 50", lat); else n_pass++;
    n_chk++;
    if ({if1.flat_input[383:376], if1.flat_input[7:0]} !== 16'h002F)
      $display("FAIL basic_input_ends: got %h want 002f", {if1.flat_input[383:376], if1.flat_input[7:0]});
    else n_pass++;
    n_chk++;
    if ({if1.flat_kernel[215:208], if1.flat_kernel[7:0]} !== 16'h809A)
      $display("FAIL basic_kernel_ends: got %h want 809a", {if1.flat_kernel[215:208], if1.flat_kernel[7:0]});
    else n_pass++;
    n_chk++;
    if (if1.flat_input !== exp_input(15'h0000))
      $display("FAIL basic_input: got %h want %h", if1.flat_input, exp_input(15'h0000));
    else n_pass++;
    n_chk++;
    if (if1.flat_kernel !== model_kernel)
      $display("FAIL basic_kernel: got %h want %h", if1.flat_kernel, model_kernel);
    else n_pass++;
    n_chk++;
    if (in_addr_errs(15'h0000) != 0 || k_addr_errs(8'h00, 1'b1) != 0)
      $display("FAIL basic_addr_seq: got in=%0d k=%0d errors want 0", in_addr_errs(15'h0000), k_addr_errs(8'h00, 1'b1));
    else n_pass++;
    accept();
    n_chk++;
    if ({cur_done, cur_valid, cur_busy} !== 3'b100)
      $display("FAIL basic_done: got done/valid/busy=%b want 100", {cur_done, cur_valid, cur_busy});
    else n_pass++;
    repeat (3) @(negedge clk);
    n_chk++;
    if (done_cnt != 1) $display("FAIL basic_done_count: got %0d want 1", done_cnt); else n_pass++;
  endtask

  task automatic test_hold();
    int lat;
    logic [IN_ADDR_W-1:0] b;
    logic [K_ADDR_W-1:0]  kb;
    b  = IN_ADDR_W'($urandom_range(0, 32767));
    kb = K_ADDR_W'($urandom_range(0, 255));
    done_cnt = 0;
    launch(b, kb, 1'b1, lat);
    model_kernel = exp_kernel(kb);
    in_q.delete();
    k_q.delete();
    for (int c = 0; c < 10; c++) begin
      start = (c == 3);
      @(negedge clk);
      n_chk++;
      if (if1.tile_valid !== 1'b1 || if1.flat_input !== exp_input(b) || if1.flat_kernel !== model_kernel)
        $display("FAIL hold_stable cyc %0d: got valid=%b in=%h k=%h want 1 %h %h", c,
                 if1.tile_valid, if1.flat_input, if1.flat_kernel, exp_input(b), model_kernel);
      else n_pass++;
    end
    start = 1'b0;
    n_chk++;
    if (in_q.size() + k_q.size() != 0)
      $display("FAIL hold_no_en: got %0d issues want 0", in_q.size() + k_q.size());
    else n_pass++;
    // start coinciding with the accepting handshake must also be ignored.
    tile_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    tile_ready = 1'b0;
    start = 1'b0;
    n_chk++;
    if ({cur_done, cur_valid, cur_busy} !== 3'b100)
      $display("FAIL hold_done: got done/valid/busy=%b want 100", {cur_done, cur_valid, cur_busy});
    else n_pass++;
    repeat (3) @(negedge clk);
    n_chk++;
    if (if1.busy !== 1'b0 || in_q.size() != 0 || done_cnt != 1)
      $display("FAIL hold_start_ignored: got busy=%b issues=%0d dones=%0d want 0 0 1", if1.busy, in_q.size(), done_cnt);
    else n_pass++;
  endtask

  task automatic test_no_kernel();
    int lat;
    launch(15'd48, K_ADDR_W'($urandom_range(0, 255)), 1'b0, lat);
    n_chk++;
    if (k_q.size() != 0) $display("FAIL nok_k_en: got %0d issues want 0", k_q.size()); else n_pass++;
    n_chk++;
    if (if1.flat_kernel !== model_kernel)
      $display("FAIL nok_kernel_kept: got %h want %h", if1.flat_kernel, model_kernel);
    else n_pass++;
    n_chk++;
    if ({if1.flat_input[383:376], if1.flat_input[7:0]} !== 16'h305F)
      $display("FAIL nok_input_ends: got %h want 305f", {if1.flat_input[383:376], if1.flat_input[7:0]});
    else n_pass++;
    n_chk++;
    if (if1.flat_input !== exp_input(15'd48))
      $display("FAIL nok_input: got %h want %h", if1.flat_input, exp_input(15'd48));
    else n_pass++;
    accept();
  endtask

  task automatic test_wrap();
    int lat;
    launch(15'h7FF0, 8'hF0, 1'b1, lat);
    model_kernel = exp_kernel(8'hF0);
    n_chk++;
    if (in_addr_errs(15'h7FF0) != 0 || in_q[16] !== 15'h0000)
      $display("FAIL wrap_in_addr: got %0d errors want 0", in_addr_errs(15'h7FF0));
    else n_pass++;
    n_chk++;
    if (k_addr_errs(8'hF0, 1'b1) != 0)
      $display("FAIL wrap_k_addr: got %0d errors want 0", k_addr_errs(8'hF0, 1'b1));
    else n_pass++;
    n_chk++;
    if (if1.flat_input[7:0] !== 8'h1F || if1.flat_input !== exp_input(15'h7FF0))
      $display("FAIL wrap_input: got %h want %h", if1.flat_input, exp_input(15'h7FF0));
    else n_pass++;
    n_chk++;
    if (if1.flat_kernel !== model_kernel)
      $display("FAIL wrap_kernel: got %h want %h", if1.flat_kernel, model_kernel);
    else n_pass++;
    accept();
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    in_base = 15'h0123; k_base = 8'h10; load_kernel = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    n_chk++;
    if (if1.in_en !== 1'b1) $display("FAIL mid_in_fetch: got in_en=%b want 1", if1.in_en); else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({if1.in_en, if1.k_en, if1.tile_valid, if1.busy, if1.done} !== 5'b0)
      $display("FAIL mid_reset_ctrl: got %b want 00000", {if1.in_en, if1.k_en, if1.tile_valid, if1.busy, if1.done});
    else n_pass++;
    n_chk++;
    if ({if1.flat_input, if1.flat_kernel} !== '0)
      $display("FAIL mid_reset_flat: got %h / %h want 0", if1.flat_input, if1.flat_kernel);
    else n_pass++;
    reset = 1'b0;
    model_kernel = '0;
    launch(15'h0000, 8'h00, 1'b1, lat);
    model_kernel = exp_kernel(8'h00);
    n_chk++;
    if (lat != 50) $display("FAIL mid_latency: got %0d want 50", lat); else n_pass++;
    n_chk++;
    if (if1.flat_input !== exp_input(15'h0000) || if1.flat_kernel !== model_kernel)
      $display("FAIL mid_data: got %h / %h want %h / %h", if1.flat_input, if1.flat_kernel, exp_input(15'h0000), model_kernel);
    else n_pass++;
    accept();
  endtask

  task automatic test_random();
    int lat, wait_cyc;
    logic [IN_ADDR_W-1:0] b;
    logic [K_ADDR_W-1:0]  kb;
    logic lk;
    for (int t = 0; t < 6; t++) begin
      b  = IN_ADDR_W'($urandom_range(0, 32767));
      kb = K_ADDR_W'($urandom_range(0, 255));
      lk = 1'($urandom_range(0, 1));
      wait_cyc = $urandom_range(0, 5);
      launch(b, kb, lk, lat);
      if (lk) model_kernel = exp_kernel(kb);
      repeat (wait_cyc) @(negedge clk);
      n_chk++;
      if (lat != 50) $display("FAIL rnd%0d_latency: got %0d want 50", t, lat); else n_pass++;
      n_chk++;
      if (if1.flat_input !== exp_input(b))
        $display("FAIL rnd%0d_input: got %h want %h", t, if1.flat_input, exp_input(b));
      else n_pass++;
      n_chk++;
      if (if1.flat_kernel !== model_kernel)
        $display("FAIL rnd%0d_kernel: got %h want %h", t, if1.flat_kernel, model_kernel);
      else n_pass++;
      n_chk++;
      if (in_addr_errs(b) != 0 || k_addr_errs(kb, lk) != 0)
        $display("FAIL rnd%0d_addr: got in=%0d k=%0d errors want 0", t, in_addr_errs(b), k_addr_errs(kb, lk));
      else n_pass++;
      accept();
      n_chk++;
      if ({cur_done, cur_valid, cur_busy} !== 3'b100)
        $display("FAIL rnd%0d_done: got done/valid/busy=%b want 100", t, {cur_done, cur_valid, cur_busy});
      else n_pass++;
    end
  endtask

  task automatic test_lat2();
    int lat;
    sel2 = 1'b1;
    launch(15'h0000, 8'h00, 1'b1, lat);
    n_chk++;
    if (lat != 51) $display("FAIL lat2_latency: got %0d want 51", lat); else n_pass++;
    n_chk++;
    if (cur_input !== exp_input(15'h0000))
      $display("FAIL lat2_input: got %h want %h", cur_input, exp_input(15'h0000));
    else n_pass++;
    n_chk++;
    if (cur_kernel !== exp_kernel(8'h00))
      $display("FAIL lat2_kernel: got %h want %h", cur_kernel, exp_kernel(8'h00));
    else n_pass++;
    accept();
    n_chk++;
    if ({cur_done, cur_valid, cur_busy} !== 3'b100)
      $display("FAIL lat2_done: got done/valid/busy=%b want 100", {cur_done, cur_valid, cur_busy});
    else n_pass++;
    sel2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_no_kernel();
    test_wrap();
    test_reset_mid();
    test_random();
    test_lat2();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
